// File: rtl/mw_pkg.sv
// Shared types and constants for the microwave cook timer: state encodings,
// the three-digit BCD time value and its decrement/shift helpers.
package mw_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t BCD_NINE = 4'd9;
    localparam digit_t BCD_FIVE = 4'd5;
    localparam digit_t BCD_ONE  = 4'd1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        COOKING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef struct packed {
        digit_t mins;
        digit_t tens;
        digit_t ones;
    } bcd_time_t;

    // One-second countdown; sec_tens may hold 6-9 and simply counts down from there.
    function automatic bcd_time_t bcd_time_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.ones != '0) begin
            r.ones = t.ones - BCD_ONE;
        end else if (t.tens != '0) begin
            r.tens = t.tens - BCD_ONE;
            r.ones = BCD_NINE;
        end else if (t.mins != '0) begin
            r.mins = t.mins - BCD_ONE;
            r.tens = BCD_FIVE;
            r.ones = BCD_NINE;
        end
        return r;
    endfunction

    // Keypad entry scrolls digits in from the right; the old minutes digit drops off.
    function automatic bcd_time_t bcd_shift_in(input bcd_time_t t, input digit_t d);
        bcd_time_t r;
        r.mins = t.tens;
        r.tens = t.ones;
        r.ones = d;
        return r;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-second tick; counts 0..TICKS_PER_SEC-1 while enabled
// and pulses tick for the cycle in which it wraps.
module sec_prescaler #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count_reg;

    // tick must not depend on clr: the controller derives clr from its next state.
    assign tick = en && (count_reg == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer controller: keypad BCD entry, per-second countdown,
// door/pause handling, magnetron enable and timed completion beep.
module microwave_timer_ctrl
    import mw_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int BEEP_SECS     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state_o
);

    localparam int BCW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
    localparam logic [BCW-1:0] BEEP_LAST = BCW'(BEEP_SECS - 1);

    state_t         state_reg, state_next;
    bcd_time_t      time_reg, time_next, time_dec_val;
    logic [BCW-1:0] beep_cnt_reg, beep_cnt_next;
    logic           mag_on_reg, beep_reg;
    logic           tick, presc_en, presc_clr;
    logic           key_ok, time_zero, dec_zero;

    // The prescaler restarts from zero on every state change so a resumed or
    // new timed phase always gets a full first second.
    assign presc_en  = (state_reg == COOKING) || (state_reg == DONE);
    assign presc_clr = !presc_en || (state_next != state_reg);

    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_sec_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    always_comb begin
        state_next    = state_reg;
        time_next     = time_reg;
        beep_cnt_next = beep_cnt_reg;
        key_ok        = key_valid && (key_digit <= BCD_NINE);
        time_dec_val  = bcd_time_dec(time_reg);
        time_zero     = (time_reg == '0);
        dec_zero      = (time_dec_val == '0);

        case (state_reg)
            IDLE, ENTRY: begin
                if (stop_clear) begin
                    if (state_reg == ENTRY) begin
                        time_next  = '0;
                        state_next = IDLE;
                    end
                end else if (start) begin
                    if (door_closed && !time_zero) begin
                        state_next = COOKING;
                    end
                end else if (key_ok) begin
                    time_next  = bcd_shift_in(time_reg, key_digit);
                    state_next = ENTRY;
                end
            end
            COOKING: begin
                // Completion outranks a door opening in the same cycle.
                if (stop_clear) begin
                    state_next = PAUSED;
                end else if (tick && dec_zero) begin
                    time_next     = '0;
                    beep_cnt_next = '0;
                    state_next    = DONE;
                end else if (!door_closed) begin
                    state_next = PAUSED;
                end else if (tick) begin
                    time_next = time_dec_val;
                end
            end
            PAUSED: begin
                if (stop_clear) begin
                    time_next  = '0;
                    state_next = IDLE;
                end else if (start && door_closed) begin
                    state_next = COOKING;
                end
            end
            DONE: begin
                // Any user event silences the beeper and is otherwise swallowed.
                if (stop_clear || start || key_valid) begin
                    state_next = IDLE;
                end else if (tick) begin
                    if (beep_cnt_reg == BEEP_LAST) begin
                        state_next = IDLE;
                    end else begin
                        beep_cnt_next = beep_cnt_reg + BCW'(1);
                    end
                end
            end
            default: begin
                time_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            time_reg     <= '0;
            beep_cnt_reg <= '0;
            mag_on_reg   <= 1'b0;
            beep_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            time_reg     <= time_next;
            beep_cnt_reg <= beep_cnt_next;
            mag_on_reg   <= (state_next == COOKING);
            beep_reg     <= (state_next == DONE);
        end
    end

    assign mins     = time_reg.mins;
    assign sec_tens = time_reg.tens;
    assign sec_ones = time_reg.ones;
    assign mag_on   = mag_on_reg;
    assign beep     = beep_reg;
    assign state_o  = state_reg;

endmodule

// File: doc/microwave_timer_ctrl.md
Name: microwave_timer_ctrl

Overview:
Sequences the microwave cook timer and drives the 7-segment decoder's three BCD digit inputs (mins, sec_tens, sec_ones).
- Accepts keypad digit entry, start, stop/clear and door status.
- Counts the entered time down once per second and controls the magnetron enable and the completion beeper.
- Sits between the keypad/door inputs and the display decoder and magnetron drive.

Parameters:
- TICKS_PER_SEC, 100, number of clk cycles per counted second. Tests use 4.
- BEEP_SECS, 3, number of seconds beep is held in DONE.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle strobe: key_digit is valid
- key_digit  in  4  keypad digit; values 0-9 accepted, 10-15 ignored
- start  in  1  one-cycle start/resume strobe
- stop_clear  in  1  one-cycle strobe: pause when cooking, clear otherwise
- door_closed  in  1  1 = door closed; synchronous to clk
- sec_ones  out  4  BCD seconds units, to decoder
- sec_tens  out  4  BCD seconds tens, to decoder
- mins  out  4  BCD minutes, to decoder
- mag_on  out  1  magnetron enable
- beep  out  1  completion beeper
- state_o  out  3  current FSM state, for debug

Behaviour:
- All outputs are registered.
- Reset (asynchronous) sets: digits 0:00, state IDLE, mag_on 0, beep 0, prescaler 0.
- States: IDLE=0, ENTRY=1, COOKING=2, PAUSED=3, DONE=4.
- Priority within a cycle: stop_clear > start > key_valid.
- Key entry (IDLE or ENTRY only) with valid digit d:
  - Shift left: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=d. The old mins digit is discarded.
  - Next state is ENTRY.
  - Digits >9 cause no change.
  - Keys are ignored in COOKING and PAUSED.
- sec_tens may legally hold 6-9 after entry; for example "1,9,0" gives 1:90, which counts as 150 s. No normalisation is done.
- start in IDLE/ENTRY: accepted only if door_closed=1 and time != 0:00.
  - Accepted: next state COOKING, prescaler cleared.
  - Otherwise ignored.
- start in PAUSED: accepted only if door_closed=1. Next state COOKING, prescaler cleared, so a partial second restarts in full.
- COOKING:
  - mag_on=1 from the cycle after the start strobe (one-cycle latency).
  - The prescaler counts 0..TICKS_PER_SEC-1. Its wrap is the tick.
- Decrement on tick:
  - sec_ones>0: sec_ones-1.
  - Else if sec_tens>0: sec_tens-1, sec_ones=9.
  - Else if mins>0: mins-1, sec_tens=5, sec_ones=9.
- Reaching 0:00 on a tick:
  - Next state DONE.
  - mag_on=0 and beep=1 in that same registered update.
- Door opens (door_closed=0) in COOKING: next state PAUSED, mag_on=0 one cycle later. The digits are held and the prescaler is frozen and then cleared.
- stop_clear actions:
  - In COOKING: go to PAUSED, digits held.
  - In PAUSED or ENTRY: clear digits to 0:00 and go to IDLE.
  - In IDLE: no effect.
- Door open while PAUSED: stay in PAUSED. Only start with the door closed resumes.
- DONE:
  - Display stays at 0:00 and beep=1.
  - The prescaler counts BEEP_SECS seconds, then the FSM goes to IDLE with beep=0.
  - stop_clear, start or key_valid in DONE goes to IDLE immediately with beep=0. That event is consumed: a key is not entered and a start does not start cooking.
- Simultaneous events:
  - A tick that reaches 0:00 in the same cycle as a door open: DONE wins.
  - stop_clear plus start together: stop_clear action only.
  - Asynchronous reset mid-cook: mag_on drops at once, without waiting for a clock edge.
- Width rules: all digit arithmetic is 4-bit BCD with no carry out. The prescaler is $clog2(TICKS_PER_SEC) bits wide.

Decomposition:
- Shared package mw_pkg holds:
  - the state encodings (IDLE..DONE)
  - BCD constants (BCD_NINE=9, BCD_FIVE=5)
  - the digit width (4)
- One sub-module, sec_prescaler:
  - Parameter TICKS_PER_SEC.
  - Inputs: clk, reset, en, clr.
  - Output: tick, a one-cycle pulse on wrap.
  - Instantiated once. Shared by COOKING and DONE.
- The FSM and the BCD down-counter stay in microwave_timer_ctrl.

Test Plan (TICKS_PER_SEC=4, BEEP_SECS=3):
- Keys 1,0,5 then start, door closed -> digits 1:05, mag_on=1 next cycle. After 4 clk: 1:04. After 24 clk: 0:59.
- Enter 0,3, start, run 12 clk -> 0:00, state DONE, mag_on=0, beep=1. Beep lasts 12 clk, then IDLE and beep=0.
- Cooking at 0:20, drop door_closed -> PAUSED next cycle, mag_on=0, digits frozen.
  - start with door open -> ignored.
  - Close door, start -> COOKING; the next decrement occurs 4 clk later.
- Enter 1,9,0, start -> count sequence 1:90, 1:89 ... 1:00, 0:59. Total 150 s of ticks to reach 0:00.
- Corner cases:
  - start at 0:00 -> stays IDLE.
  - key 12 -> no change.
  - stop_clear+start same cycle in ENTRY with 0:45 -> IDLE, 0:00.
  - stop_clear in COOKING then stop_clear again -> PAUSED, then IDLE at 0:00.
- Assert reset mid-cook at 2:30 -> mag_on=0, digits 0:00, state IDLE without a clock edge. Deassert, key 7 -> 0:07 in ENTRY.
